// File: rtl/vga_timing_gen.sv
// ----------------------------------------------------------------------------
// vga_timing_gen
// 640x480@60 Hz VGA raster timing generator. Two registered counters walk the
// raster (h_cnt across a line, v_cnt down the frame) and the sync, blanking,
// coordinate and strobe outputs are decoded from them.
//
// Region order on each axis: active, front porch, sync, back porch.
//
// Ports:
//   pixel_clk     in   1      pixel clock, all logic on the rising edge
//   reset_n       in   1      synchronous active-low reset
//   en            in   1      pixel advance enable; counters step only when 1
//   hsync_n       out  1      horizontal sync, active low
//   vsync_n       out  1      vertical sync, active low
//   active_video  out  1      high inside the visible region
//   pixel_x       out  CNT_W  current horizontal count
//   pixel_y       out  CNT_W  current vertical count
//   line_start    out  1      one-cycle strobe at h_cnt == 0
//   frame_start   out  1      one-cycle strobe at h_cnt == 0 and v_cnt == 0
//
// Build option:
//   VGA_TIMING_REG_OUT_EN  when defined, every output passes through one
//                          register stage (1-cycle latency, all outputs stay
//                          aligned). Undefined: outputs are combinational
//                          decodes of the counters, forced inactive while
//                          reset_n is low.
// ----------------------------------------------------------------------------
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int CNT_W    = 10
) (
    input  logic             pixel_clk,
    input  logic             reset_n,
    input  logic             en,
    output logic             hsync_n,
    output logic             vsync_n,
    output logic             active_video,
    output logic [CNT_W-1:0] pixel_x,
    output logic [CNT_W-1:0] pixel_y,
    output logic             line_start,
    output logic             frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CNT_W-1:0] H_LAST       = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST       = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_ACT_END    = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT_END    = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] H_SYNC_START = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] H_SYNC_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [CNT_W-1:0] V_SYNC_START = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] V_SYNC_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);

    // Inclusive range test used for both sync windows.
    function automatic logic in_range(input logic [CNT_W-1:0] val,
                                      input logic [CNT_W-1:0] lo,
                                      input logic [CNT_W-1:0] hi);
        return (val >= lo) && (val <= hi);
    endfunction

    // Next value of a wrapping counter.
    function automatic logic [CNT_W-1:0] wrap_inc(input logic [CNT_W-1:0] val,
                                                  input logic [CNT_W-1:0] last);
        return (val == last) ? '0 : val + CNT_W'(1);
    endfunction

    // ---------------- stage p0: raster counters ----------------
    logic [CNT_W-1:0] h_cnt_p0;
    logic [CNT_W-1:0] v_cnt_p0;
    logic             h_wrap_p0;

    assign h_wrap_p0 = (h_cnt_p0 == H_LAST);

    always_ff @(posedge pixel_clk) begin
        if (!reset_n) begin
            h_cnt_p0 <= '0;
            v_cnt_p0 <= '0;
        end else if (en) begin
            h_cnt_p0 <= wrap_inc(h_cnt_p0, H_LAST);
            if (h_wrap_p0) begin
                v_cnt_p0 <= wrap_inc(v_cnt_p0, V_LAST);
            end
        end
    end

    // ---------------- stage p0: combinational decode ----------------
    logic hsync_n_p0;
    logic vsync_n_p0;
    logic active_video_p0;
    logic line_start_p0;
    logic frame_start_p0;

    always_comb begin
        hsync_n_p0      = !in_range(h_cnt_p0, H_SYNC_START, H_SYNC_END);
        vsync_n_p0      = !in_range(v_cnt_p0, V_SYNC_START, V_SYNC_END);
        active_video_p0 = (h_cnt_p0 < H_ACT_END) && (v_cnt_p0 < V_ACT_END);
        // Gating with en keeps a stalled counter from re-firing the strobes.
        line_start_p0   = en && (h_cnt_p0 == '0);
        frame_start_p0  = en && (h_cnt_p0 == '0) && (v_cnt_p0 == '0);
    end

`ifdef VGA_TIMING_REG_OUT_EN
    // ---------------- stage p1: output registers ----------------
    logic             hsync_n_p1;
    logic             vsync_n_p1;
    logic             active_video_p1;
    logic [CNT_W-1:0] pixel_x_p1;
    logic [CNT_W-1:0] pixel_y_p1;
    logic             line_start_p1;
    logic             frame_start_p1;

    always_ff @(posedge pixel_clk) begin
        if (!reset_n) begin
            hsync_n_p1      <= 1'b1;
            vsync_n_p1      <= 1'b1;
            active_video_p1 <= 1'b0;
            pixel_x_p1      <= '0;
            pixel_y_p1      <= '0;
            line_start_p1   <= 1'b0;
            frame_start_p1  <= 1'b0;
        end else if (en) begin
            hsync_n_p1      <= hsync_n_p0;
            vsync_n_p1      <= vsync_n_p0;
            active_video_p1 <= active_video_p0;
            pixel_x_p1      <= h_cnt_p0;
            pixel_y_p1      <= v_cnt_p0;
            line_start_p1   <= line_start_p0;
            frame_start_p1  <= frame_start_p0;
        end else begin
            // Stalled: levels hold, strobes must not be repeated.
            line_start_p1   <= 1'b0;
            frame_start_p1  <= 1'b0;
        end
    end

    assign hsync_n      = hsync_n_p1;
    assign vsync_n      = vsync_n_p1;
    assign active_video = active_video_p1;
    assign pixel_x      = pixel_x_p1;
    assign pixel_y      = pixel_y_p1;
    assign line_start   = line_start_p1;
    assign frame_start  = frame_start_p1;
`else
    // Outputs are forced inactive for as long as reset_n is held low.
    assign hsync_n      = reset_n ? hsync_n_p0      : 1'b1;
    assign vsync_n      = reset_n ? vsync_n_p0      : 1'b1;
    assign active_video = reset_n && active_video_p0;
    assign pixel_x      = reset_n ? h_cnt_p0        : '0;
    assign pixel_y      = reset_n ? v_cnt_p0        : '0;
    assign line_start   = reset_n && line_start_p0;
    assign frame_start  = reset_n && frame_start_p0;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// ----------------------------------------------------------------------------
// tb_vga_timing_gen
// Directed bench for vga_timing_gen. Horizontal timing uses the real 640x480
// values; the vertical axis is shortened (13 lines, 2 sync lines) so full
// frames fit in a short run. A cycle model predicts every output each cycle;
// predictions are queued when inputs are driven and popped when the DUT
// output is sampled mid-cycle. Works for both the combinational and the
// VGA_TIMING_REG_OUT_EN builds.
// ----------------------------------------------------------------------------
module tb_vga_timing_gen;

    localparam int H_ACTIVE = 640;
    localparam int H_FP     = 16;
    localparam int H_SYNC   = 96;
    localparam int H_BP     = 48;
    localparam int V_ACTIVE = 6;
    localparam int V_FP     = 2;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 3;
    localparam int CNT_W    = 10;
    localparam int HT       = 800;
    localparam int VT       = 13;

`ifdef VGA_TIMING_REG_OUT_EN
    localparam bit REG_OUT = 1'b1;
    localparam int LAT     = 1;
`else
    localparam bit REG_OUT = 1'b0;
    localparam int LAT     = 0;
`endif

    logic             pixel_clk = 1'b0;
    logic             reset_n   = 1'b0;
    logic             en        = 1'b0;
    logic             hsync_n;
    logic             vsync_n;
    logic             active_video;
    logic [CNT_W-1:0] pixel_x;
    logic [CNT_W-1:0] pixel_y;
    logic             line_start;
    logic             frame_start;

    always #5 pixel_clk = ~pixel_clk;

    vga_timing_gen #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
        .CNT_W(CNT_W)
    ) dut (
        .pixel_clk   (pixel_clk),
        .reset_n     (reset_n),
        .en          (en),
        .hsync_n     (hsync_n),
        .vsync_n     (vsync_n),
        .active_video(active_video),
        .pixel_x     (pixel_x),
        .pixel_y     (pixel_y),
        .line_start  (line_start),
        .frame_start (frame_start)
    );

    typedef struct packed {
        logic             hs;
        logic             vs;
        logic             av;
        logic [CNT_W-1:0] x;
        logic [CNT_W-1:0] y;
        logic             ls;
        logic             fs;
    } obs_t;

    obs_t exp_q[$];
    obs_t reg_cur;
    obs_t last;
    int   m_h = 0;
    int   m_v = 0;
    int   checks = 0;
    int   errors = 0;
    int   sidx = 0;
    int   fs_at = -1;
    int   hs_low = 0, vs_low = 0, ls_n = 0, fs_n = 0;
    int   av_fall_x = -1, hs_fall_x = -1, hs_rise_x = -1;
    logic prev_av = 1'b0, prev_hs = 1'b1;

    function automatic obs_t decode(input int h, input int v, input logic e);
        obs_t d;
        d.hs = !(h >= 656 && h <= 751);
        d.vs = !(v >= V_ACTIVE + V_FP && v <= V_ACTIVE + V_FP + V_SYNC - 1);
        d.av = (h < 640) && (v < V_ACTIVE);
        d.x  = CNT_W'(h);
        d.y  = CNT_W'(v);
        d.ls = e && (h == 0);
        d.fs = e && (h == 0) && (v == 0);
        return d;
    endfunction

    function automatic obs_t inactive();
        obs_t d;
        d.hs = 1'b1; d.vs = 1'b1; d.av = 1'b0;
        d.x  = '0;   d.y  = '0;
        d.ls = 1'b0; d.fs = 1'b0;
        return d;
    endfunction

    task automatic check(input string tag, input int got, input int want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, got, want);
        end
    endtask

    // One pixel cycle: drive at posedge+1, compare at negedge, advance the
    // model at the following posedge.
    task automatic step(input logic e, input logic r);
        obs_t e_obs;
        obs_t got;
        en      = e;
        reset_n = r;
        if (REG_OUT) e_obs = reg_cur;
        else         e_obs = r ? decode(m_h, m_v, e) : inactive();
        exp_q.push_back(e_obs);
        @(negedge pixel_clk);
        got.hs = hsync_n;  got.vs = vsync_n;  got.av = active_video;
        got.x  = pixel_x;  got.y  = pixel_y;
        got.ls = line_start; got.fs = frame_start;
        e_obs = exp_q.pop_front();
        checks++;
        assert (got === e_obs) else begin
            errors++;
            $error("FAIL scoreboard step=%0d observed=%h expected=%h (hs vs av x y ls fs)",
                   sidx, got, e_obs);
        end
        sidx++;
        if (!got.hs) hs_low++;
        if (!got.vs) vs_low++;
        if (got.ls) ls_n++;
        if (got.fs) fs_n++;
        if (got.fs && fs_at < 0) fs_at = sidx;
        if (prev_av && !got.av && av_fall_x < 0) av_fall_x = int'(got.x);
        if (prev_hs && !got.hs && hs_fall_x < 0) hs_fall_x = int'(got.x);
        if (!prev_hs && got.hs && hs_rise_x < 0) hs_rise_x = int'(got.x);
        prev_av = got.av;
        prev_hs = got.hs;
        last = got;
        @(posedge pixel_clk);
        if (!r)     reg_cur = inactive();
        else if (e) reg_cur = decode(m_h, m_v, 1'b1);
        else begin
            reg_cur.ls = 1'b0;
            reg_cur.fs = 1'b0;
        end
        if (!r) begin
            m_h = 0; m_v = 0;
        end else if (e) begin
            if (m_h == HT - 1) begin
                m_h = 0;
                m_v = (m_v == VT - 1) ? 0 : m_v + 1;
            end else begin
                m_h = m_h + 1;
            end
        end
        #1;
    endtask

    task automatic clear_tallies();
        hs_low = 0; vs_low = 0; ls_n = 0; fs_n = 0;
    endtask

    // Run enabled cycles until (tx, ty) is shown; ty < 0 matches any line.
    task automatic run_until(input int tx, input int ty, input int bound,
                             input string tag, output int n);
        logic found;
        n = 0;
        found = (int'(last.x) == tx) && (ty < 0 || int'(last.y) == ty);
        while (!found && n < bound) begin
            step(1'b1, 1'b1);
            n++;
            found = (int'(last.x) == tx) && (ty < 0 || int'(last.y) == ty);
        end
        check(tag, int'(found), 1);
    endtask

    initial begin
        int n1, n2;
        reg_cur = inactive();
        last    = inactive();
        repeat (2) @(posedge pixel_clk);
        #1;

        // Reset state, including en=1 while held in reset
        repeat (3) step(1'b0, 1'b0);
        check("reset_state", int'(last), int'(inactive()));
        step(1'b1, 1'b0);
        check("reset_dominates_en", int'(last), int'(inactive()));

        // Release and first line
        sidx = 0; fs_at = -1; clear_tallies();
        av_fall_x = -1; hs_fall_x = -1; hs_rise_x = -1;
        repeat (1 + LAT) step(1'b1, 1'b1);
        check("first_x", int'(last.x), 0);
        check("first_y", int'(last.y), 0);
        check("first_active", int'(last.av), 1);
        check("first_line_start", int'(last.ls), 1);
        check("first_frame_start", int'(last.fs), 1);
        check("first_syncs", int'({last.hs, last.vs}), 3);
        check("frame_start_cycle", fs_at, 1 + LAT);
        repeat (HT - 1) step(1'b1, 1'b1);
        check("hsync_low_cycles", hs_low, 96);
        check("hsync_fall_x", hs_fall_x, 656);
        check("hsync_rise_x", hs_rise_x, 752);
        check("active_fall_x", av_fall_x, 640);
        check("line0_line_starts", ls_n, 1);
        step(1'b1, 1'b1);
        check("line1_x", int'(last.x), 0);
        check("line1_y", int'(last.y), 1);
        check("line1_line_start", int'(last.ls), 1);
        check("line1_frame_start", int'(last.fs), 0);

        // Stall at h=100
        run_until(99, -1, 900, "reach_x99", n1);
        clear_tallies();
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b1);
            check("stall100_x", int'(last.x), 100);
        end
        check("stall100_strobes", ls_n + fs_n, 0);
        run_until(0, -1, 900, "stall100_line_end", n2);
        check("stall100_line_len", n1 + 5 + n2, HT + 5);

        // Stall at h=0
        run_until(HT - 1, -1, 900, "reach_x799", n1);
        clear_tallies();
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b1);
            check("stall0_x", int'(last.x), 0);
        end
        check("stall0_ls_during", ls_n, LAT);
        check("stall0_fs_during", fs_n, 0);
        repeat (10) step(1'b1, 1'b1);
        check("stall0_ls_total", ls_n, 1);

        // Full frame, frame_start to frame_start
        n1 = 0;
        while (!last.fs && n1 < HT * VT + 100) begin
            step(1'b1, 1'b1);
            n1++;
        end
        check("reach_frame_start", int'(last.fs), 1);
        clear_tallies();
        repeat (HT * VT) step(1'b1, 1'b1);
        check("frame_fs_count", fs_n, 1);
        check("frame_ls_count", ls_n, VT);
        check("frame_vsync_low", vs_low, V_SYNC * HT);
        check("frame_hsync_low", hs_low, VT * 96);
        check("frame_wrap_fs", int'(last.fs), 1);
        check("frame_wrap_xy", int'({last.x, last.y}), 0);

        // Reset mid-frame inside the vertical sync
        run_until(700, V_ACTIVE + V_FP + V_SYNC - 1, HT * VT + 100, "reach_700_sync", n1);
        check("mid_vsync_low", int'(last.vs), 0);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        check("mid_reset_forced", int'(last), int'(inactive()));
        repeat (1 + LAT) step(1'b1, 1'b1);
        check("restart_fs", int'(last.fs), 1);
        check("restart_xy", int'({last.x, last.y}), 0);
        check("restart_active", int'(last.av), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
